// File: rtl/fetch_queue_ctrl.sv
// Instruction prefetch sequencer: issues in-order word fetches, pushes {pc, inst}
// into the fetch SyncQueue, and reserves queue space for every live in-flight request.
module fetch_queue_ctrl #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          QUEUE_SIZE      = 32,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        mem_req_ready,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        q_wvalid,
    output logic [63:0] q_wdata,
    output logic        q_kill,
    input  logic        q_rfire
);
    localparam int CW = $clog2(QUEUE_SIZE) + 1;
    localparam int SW = CW + 1;
    localparam logic [SW-1:0] FILL_LIMIT = SW'(QUEUE_SIZE - 2);
    localparam logic [CW-1:0] MAX_O      = CW'(MAX_OUTSTANDING);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] o_cnt;
    logic [CW-1:0] s_cnt;
    logic [CW-1:0] occ;

    logic [CW-1:0] live;
    logic [SW-1:0] fill;
    logic          req_fire;
    logic          resp_live;
    logic          resp_stale;
    logic [CW-1:0] o_after_resp;
    logic [CW-1:0] o_next;

    // Handshake: a request transfers on a cycle with mem_req_valid && mem_req_ready;
    // responses come back in issue order and cannot be stalled.
    always_comb begin
        live          = o_cnt - s_cnt;
        fill          = {1'b0, occ} + {1'b0, live};
        mem_req_valid = (state == RUN) && !redirect_valid && (o_cnt < MAX_O) && (fill < FILL_LIMIT);
        mem_req_addr  = fetch_pc;
        req_fire      = mem_req_valid && mem_req_ready;
        resp_live     = mem_resp_valid && !redirect_valid && (s_cnt == '0);
        resp_stale    = mem_resp_valid && !redirect_valid && (s_cnt != '0);
        q_wvalid      = resp_live;
        q_wdata       = {resp_pc, mem_resp_data};
        q_kill        = redirect_valid;
        o_after_resp  = o_cnt - CW'(mem_resp_valid);
        o_next        = o_after_resp + CW'(req_fire);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            o_cnt    <= '0;
            s_cnt    <= '0;
            occ      <= '0;
        end else begin
            state <= RUN;
            o_cnt <= o_next;
            if (redirect_valid) begin
                // Everything still outstanding after this cycle belongs to the old stream.
                s_cnt    <= o_after_resp;
                occ      <= '0;
                fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
                resp_pc  <= redirect_pc & 32'hFFFF_FFFC;
            end else begin
                s_cnt <= s_cnt - CW'(resp_stale);
                occ   <= occ + CW'(q_wvalid) - CW'(q_rfire);
                if (req_fire)
                    fetch_pc <= fetch_pc + 32'd4;
                if (resp_live)
                    resp_pc <= resp_pc + 32'd4;
            end
        end
    end

    a_counts_ordered: assert property (@(posedge clk) disable iff (reset)
        (s_cnt <= o_cnt) && (o_cnt <= MAX_O));
    a_fill_bound: assert property (@(posedge clk) disable iff (reset)
        fill <= FILL_LIMIT);
    a_push_not_killed: assert property (@(posedge clk) disable iff (reset)
        !(q_wvalid && q_kill));
    a_resp_expected: assert property (@(posedge clk) disable iff (reset)
        !(mem_resp_valid && (o_cnt == '0)));

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Bench for fetch_queue_ctrl: in-order memory model with random latency, random pops
// and redirects, checked each cycle against a request/queue-level reference model.
module tb_fetch_queue_ctrl;
    localparam int          QS       = 32;
    localparam int          MAXO     = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_ready;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        q_wvalid;
    logic [63:0] q_wdata;
    logic        q_kill;
    logic        q_rfire;

    fetch_queue_ctrl #(
        .RESET_PC(RESET_PC), .QUEUE_SIZE(QS), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_ready(mem_req_ready), .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .q_wvalid(q_wvalid), .q_wdata(q_wdata), .q_kill(q_kill), .q_rfire(q_rfire)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; bit stale; } req_t;
    typedef struct { int due; logic [31:0] data; } resp_t;

    // reference model: in-flight request list, pending memory responses, queue count
    req_t        inflight[$];
    resp_t       pend[$];
    bit          m_run;
    logic [31:0] m_fetch_pc;
    int          m_occ;
    int          max_inflight;

    int cyc, last_due;
    int lat_min, lat_max, ready_pct, pop_pct;
    int n_checks, n_pass;

    logic [31:0] req_log[$];
    logic [31:0] push_log[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // driver task: one clock cycle of stimulus, comparison and model update
    task automatic cycle(input bit rst, input bit redir, input logic [31:0] rpc);
        int          live;
        bit          exp_req;
        bit          exp_w;
        logic [63:0] exp_wdata;
        req_t        r;
        resp_t       p;
        int          lat;
        @(negedge clk);
        reset          = rst;
        redirect_valid = redir;
        redirect_pc    = rpc;
        mem_req_ready  = ($urandom_range(99) < ready_pct);
        if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = pend[0].data;
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = $urandom;
        end
        q_rfire = !rst && (m_occ > 0) && ($urandom_range(99) < pop_pct);
        #1;
        if (rst) begin
            m_run      = 1'b0;
            m_fetch_pc = RESET_PC;
            m_occ      = 0;
            inflight.delete();
            pend.delete();
            last_due   = cyc;
        end else begin
            live = 0;
            foreach (inflight[i]) if (!inflight[i].stale) live++;
            exp_req   = m_run && !redir && (inflight.size() < MAXO) && (m_occ + live < QS - 2);
            exp_w     = 1'b0;
            exp_wdata = '0;
            if (mem_resp_valid && inflight.size() > 0) begin
                exp_w     = !redir && !inflight[0].stale;
                exp_wdata = {inflight[0].addr, mem_resp_data};
            end
            check("mem_req_valid", 64'(mem_req_valid), 64'(exp_req));
            check("q_kill", 64'(q_kill), 64'(redir));
            check("q_wvalid", 64'(q_wvalid), 64'(exp_w));
            if (exp_req) check("mem_req_addr", 64'(mem_req_addr), 64'(m_fetch_pc));
            if (exp_w)   check("q_wdata", q_wdata, exp_wdata);

            if (mem_req_valid && mem_req_ready) req_log.push_back(mem_req_addr);
            if (q_wvalid) push_log.push_back(q_wdata[63:32]);

            if (mem_resp_valid && inflight.size() > 0) begin
                void'(pend.pop_front());
                void'(inflight.pop_front());
            end
            if (exp_req && mem_req_ready) begin
                r.addr  = m_fetch_pc;
                r.stale = 1'b0;
                inflight.push_back(r);
                lat    = $urandom_range(lat_max, lat_min);
                p.due  = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                p.data = $urandom;
                pend.push_back(p);
                last_due   = p.due;
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
            if (inflight.size() > max_inflight) max_inflight = inflight.size();
            if (redir) begin
                foreach (inflight[i]) inflight[i].stale = 1'b1;
                m_occ      = 0;
                m_fetch_pc = rpc & 32'hFFFF_FFFC;
            end else begin
                m_occ = m_occ + int'(exp_w) - int'(q_rfire);
            end
            m_run = 1'b1;
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
    endtask

    function automatic logic [31:0] log_at(input int which, input int idx);
        if (which == 0) return (req_log.size() > idx) ? req_log[idx] : 32'hDEAD_BEEF;
        return (push_log.size() > idx) ? push_log[idx] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        bit in_order;
        n_checks = 0; n_pass = 0; cyc = 0; last_due = 0; max_inflight = 0;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_data = '0; q_rfire = 1'b0;
        m_run = 1'b0; m_fetch_pc = RESET_PC; m_occ = 0;

        // Fill with 1-cycle memory and no pops: exactly 30 pushes, sequential pcs.
        lat_min = 1; lat_max = 1; ready_pct = 100; pop_pct = 0;
        do_reset();
        cycle(1'b0, 1'b0, 32'h0);
        check("idle_no_req", 64'(mem_req_valid), 64'd0);
        cycle(1'b0, 1'b0, 32'h0);
        check("first_req_valid", 64'(mem_req_valid), 64'd1);
        check("first_req_addr", 64'(mem_req_addr), 64'h0);
        run(60);
        check("fill_push_count", 64'(push_log.size()), 64'd30);
        check("fill_model_occ", 64'(m_occ), 64'd30);
        check("fill_req_stalled", 64'(mem_req_valid), 64'd0);
        in_order = 1'b1;
        foreach (push_log[i]) if (push_log[i] != 32'(4 * i)) in_order = 1'b0;
        check("fill_pcs_in_order", 64'(in_order), 64'd1);

        // Long latency: outstanding count saturates at MAX_OUTSTANDING.
        lat_min = 6; lat_max = 6; pop_pct = 50; max_inflight = 0;
        do_reset();
        run(120);
        check("outstanding_saturates", 64'(max_inflight), 64'(MAXO));

        // Redirect to an unaligned pc in the middle of traffic.
        lat_min = 3; lat_max = 3; pop_pct = 30;
        do_reset();
        run(12);
        req_log.delete(); push_log.delete();
        cycle(1'b0, 1'b1, 32'h0000_1002);
        run(20);
        check("redir_first_req", 64'(log_at(0, 0)), 64'h1000);
        check("redir_first_push", 64'(log_at(1, 0)), 64'h1000);

        // Back-to-back redirects: the last one wins.
        req_log.delete(); push_log.delete();
        cycle(1'b0, 1'b1, 32'h0000_2000);
        cycle(1'b0, 1'b1, 32'h0000_3004);
        run(20);
        check("b2b_first_req", 64'(log_at(0, 0)), 64'h3004);
        check("b2b_first_push", 64'(log_at(1, 0)), 64'h3004);

        // Address wrap at the top of memory.
        lat_min = 1; lat_max = 4; pop_pct = 60;
        req_log.delete();
        cycle(1'b0, 1'b1, 32'hFFFF_FFFE);
        run(10);
        check("wrap_req0", 64'(log_at(0, 0)), 64'hFFFF_FFFC);
        check("wrap_req1", 64'(log_at(0, 1)), 64'h0);

        // Redirect while still in IDLE.
        do_reset();
        req_log.delete();
        cycle(1'b0, 1'b1, 32'h0000_0203);
        cycle(1'b0, 1'b0, 32'h0);
        check("idle_redir_addr", 64'(mem_req_addr), 64'h200);
        run(5);

        // Random traffic with random redirects, pops and latencies.
        lat_min = 1; lat_max = 8; ready_pct = 70; pop_pct = 60;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(99) < 8) cycle(1'b0, 1'b1, $urandom);
            else cycle(1'b0, 1'b0, 32'h0);
        end

        // Reset in the middle of traffic: restart at RESET_PC after one IDLE cycle.
        lat_min = 5; lat_max = 5; ready_pct = 100;
        run(6);
        cycle(1'b0, 1'b1, 32'h0000_4000);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        check("post_reset_idle", 64'(mem_req_valid), 64'd0);
        check("post_reset_no_push", 64'(q_wvalid), 64'd0);
        cycle(1'b0, 1'b0, 32'h0);
        check("post_reset_req", 64'(mem_req_valid), 64'd1);
        check("post_reset_addr", 64'(mem_req_addr), 64'(RESET_PC));
        run(30);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
